// File: rtl/ps2_key_tracker_if.sv
// PS/2 byte stream from the receiver into the key tracker.
// One-cycle byte_valid strobe qualifies byte_in.
interface ps2_key_tracker_if;
  logic [7:0] byte_in;
  logic       byte_valid;

  modport master (
    output byte_in,
    output byte_valid
  );

  modport slave (
    input byte_in,
    input byte_valid
  );
endinterface

// File: rtl/ps2_key_tracker.sv
// Set-2 scan-code decoder: make/break/repeat events, held key,
// Shift/CapsLock state and a BCD count of key presses.
module ps2_key_tracker #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned TO_W           = 20
) (
  input  logic              clk,
  input  logic              rst,
  ps2_key_tracker_if.slave  rx,
  output logic [7:0]        key_code,
  output logic              key_ext,
  output logic              key_held,
  output logic              press_pulse,
  output logic              release_pulse,
  output logic              repeat_pulse,
  output logic [7:0]        press_cnt,
  output logic              shift_on,
  output logic              caps_on,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t          state_q, state_d;
  logic [TO_W-1:0] to_q, to_d;

  logic       lshift_q, lshift_d;
  logic       rshift_q, rshift_d;
  logic       caps_held_q, caps_held_d;

  logic [7:0] code_d;
  logic       ext_d, held_d;
  logic       press_d, rel_d, rep_d;
  logic [7:0] cnt_d;
  logic       shift_d, caps_d, err_d;

  logic       ev_make, ev_brk, ev_ext;
  logic       match;

  logic [7:0] b;
  logic       is_e0, is_f0, is_drop, is_err;

  assign b       = rx.byte_in;
  assign is_e0   = (b == 8'hE0);
  assign is_f0   = (b == 8'hF0);
  assign is_drop = (b == 8'hAA) || (b == 8'hFA) ||
                   (b == 8'hEE) || (b == 8'hFE);
  assign is_err  = (b == 8'h00) || (b == 8'hFF);
  assign match   = key_held && (b == key_code) &&
                   (ev_ext == key_ext);

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      r[7:4] = (v[7:4] == 4'd9) ? 4'd0 : v[7:4] + 4'd1;
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  // Prefix FSM and timeout: classify each byte into an event.
  always_comb begin
    state_d = state_q;
    to_d    = to_q;
    ev_make = 1'b0;
    ev_brk  = 1'b0;
    ev_ext  = 1'b0;
    err_d   = 1'b0;
    if (rx.byte_valid) begin
      to_d = '0;
      unique case (state_q)
        IDLE: begin
          unique case (1'b1)
            is_e0:   state_d = EXT;
            is_f0:   state_d = BRK;
            is_drop: state_d = IDLE;
            is_err:  err_d   = 1'b1;
            default: ev_make = 1'b1;
          endcase
        end
        EXT: begin
          unique case (1'b1)
            is_f0:   state_d = EXT_BRK;
            is_e0:   state_d = EXT;
            default: begin
              ev_make = 1'b1;
              ev_ext  = 1'b1;
              state_d = IDLE;
            end
          endcase
        end
        BRK: begin
          ev_brk  = 1'b1;
          state_d = IDLE;
        end
        EXT_BRK: begin
          ev_brk  = 1'b1;
          ev_ext  = 1'b1;
          state_d = IDLE;
        end
      endcase
    end else if (state_q != IDLE) begin
      if (to_q == TO_LAST) begin
        state_d = IDLE;
        to_d    = '0;
      end else begin
        to_d = to_q + 1'b1;
      end
    end else begin
      to_d = '0;
    end
  end

  // Apply make/break events to held key, counter and modifiers.
  always_comb begin
    code_d      = key_code;
    ext_d       = key_ext;
    held_d      = key_held;
    press_d     = 1'b0;
    rel_d       = 1'b0;
    rep_d       = 1'b0;
    cnt_d       = press_cnt;
    lshift_d    = lshift_q;
    rshift_d    = rshift_q;
    caps_held_d = caps_held_q;
    caps_d      = caps_on;
    if (ev_make) begin
      if (match) begin
        rep_d = 1'b1;
      end else begin
        code_d  = b;
        ext_d   = ev_ext;
        held_d  = 1'b1;
        press_d = 1'b1;
        cnt_d   = bcd_inc(press_cnt);
      end
      if (!ev_ext) begin
        if (b == 8'h12) lshift_d = 1'b1;
        if (b == 8'h59) rshift_d = 1'b1;
        if (b == 8'h58 && !caps_held_q) begin
          caps_d      = ~caps_on;
          caps_held_d = 1'b1;
        end
      end
    end
    if (ev_brk) begin
      if (match) begin
        held_d = 1'b0;
        rel_d  = 1'b1;
      end
      if (!ev_ext) begin
        if (b == 8'h12) lshift_d = 1'b0;
        if (b == 8'h59) rshift_d = 1'b0;
        if (b == 8'h58) caps_held_d = 1'b0;
      end
    end
    shift_d = lshift_d | rshift_d;
  end

  // State, timeout counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      to_q          <= '0;
      lshift_q      <= 1'b0;
      rshift_q      <= 1'b0;
      caps_held_q   <= 1'b0;
      key_code      <= 8'h00;
      key_ext       <= 1'b0;
      key_held      <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;
      press_cnt     <= 8'h00;
      shift_on      <= 1'b0;
      caps_on       <= 1'b0;
      err           <= 1'b0;
    end else begin
      state_q       <= state_d;
      to_q          <= to_d;
      lshift_q      <= lshift_d;
      rshift_q      <= rshift_d;
      caps_held_q   <= caps_held_d;
      key_code      <= code_d;
      key_ext       <= ext_d;
      key_held      <= held_d;
      press_pulse   <= press_d;
      release_pulse <= rel_d;
      repeat_pulse  <= rep_d;
      press_cnt     <= cnt_d;
      shift_on      <= shift_d;
      caps_on       <= caps_d;
      err           <= err_d;
    end
  end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Bench for ps2_key_tracker: directed sequences plus random
// byte streams compared against a flag-based reference model.
module tb_ps2_key_tracker;

  localparam int T = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] key_code;
  logic       key_ext, key_held;
  logic       press_pulse, release_pulse, repeat_pulse;
  logic [7:0] press_cnt;
  logic       shift_on, caps_on, err;

  ps2_key_tracker_if rx ();

  ps2_key_tracker #(
    .TIMEOUT_CYCLES(T),
    .TO_W(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx.slave),
    .key_code(key_code),
    .key_ext(key_ext),
    .key_held(key_held),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .repeat_pulse(repeat_pulse),
    .press_cnt(press_cnt),
    .shift_on(shift_on),
    .caps_on(caps_on),
    .err(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // reference model state
  logic [7:0] m_code;
  logic m_ext, m_held, m_press, m_rel, m_rep, m_err;
  logic m_lsh, m_rsh, m_caps, m_caps_held;
  int   m_cnt;
  logic pend_ext, pend_brk;
  int   gap;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string w);
    logic [7:0] ecnt;
    ecnt = 8'(((m_cnt / 10) * 16) + (m_cnt % 10));
    chk({w, ":code"}, 32'(key_code), 32'(m_code));
    chk({w, ":ext"}, 32'(key_ext), 32'(m_ext));
    chk({w, ":held"}, 32'(key_held), 32'(m_held));
    chk({w, ":press"}, 32'(press_pulse), 32'(m_press));
    chk({w, ":rel"}, 32'(release_pulse), 32'(m_rel));
    chk({w, ":rep"}, 32'(repeat_pulse), 32'(m_rep));
    chk({w, ":cnt"}, 32'(press_cnt), 32'(ecnt));
    chk({w, ":shift"}, 32'(shift_on), 32'(m_lsh | m_rsh));
    chk({w, ":caps"}, 32'(caps_on), 32'(m_caps));
    chk({w, ":err"}, 32'(err), 32'(m_err));
  endtask

  task automatic model_reset();
    m_code = 8'h00; m_ext = 0; m_held = 0;
    m_press = 0; m_rel = 0; m_rep = 0; m_err = 0;
    m_lsh = 0; m_rsh = 0; m_caps = 0; m_caps_held = 0;
    m_cnt = 0; pend_ext = 0; pend_brk = 0; gap = 0;
  endtask

  task automatic clear_pulses();
    m_press = 0; m_rel = 0; m_rep = 0; m_err = 0;
  endtask

  task automatic model_make(input logic [7:0] c, input logic x);
    if (m_held && c == m_code && x == m_ext) begin
      m_rep = 1;
    end else begin
      m_code = c; m_ext = x; m_held = 1; m_press = 1;
      m_cnt = (m_cnt + 1) % 100;
    end
    if (!x && c == 8'h12) m_lsh = 1;
    if (!x && c == 8'h59) m_rsh = 1;
    if (!x && c == 8'h58) begin
      if (!m_caps_held) m_caps = ~m_caps;
      m_caps_held = 1;
    end
  endtask

  task automatic model_break(input logic [7:0] c, input logic x);
    if (m_held && c == m_code && x == m_ext) begin
      m_held = 0; m_rel = 1;
    end
    if (!x && c == 8'h12) m_lsh = 0;
    if (!x && c == 8'h59) m_rsh = 0;
    if (!x && c == 8'h58) m_caps_held = 0;
  endtask

  task automatic model_byte(input logic [7:0] c);
    clear_pulses();
    if (gap >= T) begin
      pend_ext = 0; pend_brk = 0;
    end
    gap = 0;
    if (pend_brk) begin
      model_break(c, pend_ext);
      pend_brk = 0; pend_ext = 0;
    end else if (pend_ext) begin
      if (c == 8'hF0) pend_brk = 1;
      else if (c != 8'hE0) begin
        model_make(c, 1);
        pend_ext = 0;
      end
    end else begin
      case (c)
        8'hE0: pend_ext = 1;
        8'hF0: pend_brk = 1;
        8'hAA, 8'hFA, 8'hEE, 8'hFE: ;
        8'h00, 8'hFF: m_err = 1;
        default: model_make(c, 0);
      endcase
    end
  endtask

  // Called at a negedge; returns at the next negedge after checking.
  task automatic send(input logic [7:0] c, input string w);
    model_byte(c);
    rx.byte_in = c;
    rx.byte_valid = 1'b1;
    @(negedge clk);
    rx.byte_valid = 1'b0;
    check_all(w);
  endtask

  task automatic idle(input int n);
    if (n > 0) begin
      @(negedge clk);
      clear_pulses();
      check_all("idle");
      repeat (n - 1) @(negedge clk);
      gap += n;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_all("reset");
  endtask

  logic [7:0] pool [16] = '{8'h1C, 8'h1C, 8'h75, 8'h12, 8'h59,
                            8'h58, 8'hE0, 8'hE0, 8'hF0, 8'hF0,
                            8'hF0, 8'h00, 8'hFF, 8'hAA, 8'h23,
                            8'h5A};

  initial begin
    rx.byte_in = 8'h00;
    rx.byte_valid = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    send(8'h1C, "mk1c");
    send(8'hF0, "f0");
    send(8'h1C, "bk1c");

    send(8'hE0, "e0");
    send(8'h75, "mk_e75");
    send(8'hE0, "e0");
    send(8'hF0, "f0");
    send(8'h75, "bk_e75");
    send(8'h75, "mk75");
    send(8'hE0, "e0");
    send(8'hF0, "f0");
    send(8'h75, "bk_e75_mis");

    do_reset();
    send(8'h1C, "rp0");
    send(8'h1C, "rp1");
    send(8'h1C, "rp2");
    send(8'hF0, "f0");
    send(8'h1C, "rp_bk");

    do_reset();
    for (int i = 1; i <= 100; i++) begin
      send(8'(i), "cnt_mk");
      send(8'hF0, "cnt_f0");
      send(8'(i), "cnt_bk");
      if (i == 10) chk("cnt_10", 32'(press_cnt), 32'h10);
      if (i == 99) chk("cnt_99", 32'(press_cnt), 32'h99);
    end
    chk("cnt_wrap", 32'(press_cnt), 32'h00);

    send(8'hF0, "to_f0");
    idle(T);
    send(8'h1C, "to_mk");
    send(8'hF0, "to_f0b");
    idle(T - 1);
    send(8'h1C, "to_edge_bk");
    send(8'h00, "err00");
    send(8'hFF, "errff");

    do_reset();
    send(8'h12, "lsh_mk");
    send(8'h58, "caps_mk");
    send(8'h58, "caps_rp");
    send(8'hF0, "f0");
    send(8'h58, "caps_bk");
    send(8'hF0, "f0");
    send(8'h12, "lsh_bk");
    send(8'hE0, "e0");
    send(8'h12, "e12_mk");

    send(8'hE0, "rst_ext");
    rst = 1'b1;
    rx.byte_in = 8'h1C;
    rx.byte_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rx.byte_valid = 1'b0;
    model_reset();
    check_all("rst_in_ext");
    send(8'h1C, "post_rst_mk");

    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 19));
      if (r == 19) do_reset();
      else if (r >= 16) idle(T - 2 + int'($urandom_range(0, 3)));
      else if (r >= 12) idle(int'($urandom_range(1, 3)));
      send(pool[$urandom_range(0, 15)], "rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
